// File: rtl/mean_filter_pkg.sv
// Shared constants and types for the 3x3 mean filter path.
package mean_filter_pkg;

  localparam int PIX_W  = 8;
  localparam int RECIP9 = 7282;
  localparam int RND    = 32768;
  localparam int SHIFT  = 16;
  localparam int LAT    = 5;
  localparam int ROW_W  = 10;
  localparam int SUM_W  = 12;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

endpackage

// File: rtl/mean_div9.sv
// Registered rounded divide-by-9 of a 3x3 window sum; holds when not enabled.
module mean_div9
  import mean_filter_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SUM_W-1:0] sum_i,
  output pix_t             mean_o
);

  localparam int PROD_W = 26;

  // Reciprocal multiply is exact for every sum in 0..2295.
  function automatic pix_t div9_round(input logic [SUM_W-1:0] s);
    logic [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'(RECIP9) + PROD_W'(RND);
    return pix_t'(p >> SHIFT);
  endfunction

  pix_t mean_d, mean_q;

  always_comb begin
    mean_d = mean_q;
    if (en) mean_d = div9_round(sum_i);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) mean_q <= '0;
    else        mean_q <= mean_d;
  end

  assign mean_o = mean_q;

endmodule

// File: rtl/mean3x3_window_core.sv
// 3x3 window assembly from line taps, rounded mean, border handling and
// sync delay matching; one pixel per cycle, 5-cycle latency.
module mean3x3_window_core
  import mean_filter_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter bit BORDER_RAW = 1'b1
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_y,
  input  logic [7:0] taps0x,
  input  logic [7:0] taps1x,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [7:0] post_img_y
);

  sync_t sync_p0_d, sync_p0_q, sync_p1_d, sync_p1_q, sync_p2_d, sync_p2_q;
  sync_t sync_p3_d, sync_p3_q, sync_p4_d, sync_p4_q;
  pix_t  pix_p0_d, pix_p0_q;
  pix_t  raw_p1_d, raw_p1_q, raw_p2_d, raw_p2_q, raw_p3_d, raw_p3_q, raw_p4_d, raw_p4_q;
  logic  border_p1_d, border_p1_q, border_p2_d, border_p2_q;
  logic  border_p3_d, border_p3_q, border_p4_d, border_p4_q;
  logic [2:0][2:0][PIX_W-1:0] win_d, win_q;
  logic [2:0][ROW_W-1:0]      rsum_p2_d, rsum_p2_q;
  logic [SUM_W-1:0]           sum_p3_d, sum_p3_q;
  logic [CNT_W-1:0]           col_cnt_d, col_cnt_q, row_cnt_d, row_cnt_q;
  logic vld_p0, vld_p1, vld_p2, vld_p3;
  logic vs_rise, href_fall;
  pix_t mean_p4;

  assign vld_p0    = sync_p0_q.clken & sync_p0_q.href;
  assign vld_p1    = sync_p1_q.clken & sync_p1_q.href;
  assign vld_p2    = sync_p2_q.clken & sync_p2_q.href;
  assign vld_p3    = sync_p3_q.clken & sync_p3_q.href;
  assign vs_rise   = sync_p0_q.vsync & ~sync_p1_q.vsync;
  assign href_fall = ~sync_p0_q.href & sync_p1_q.href;

  always_comb begin
    // Stage 0: align the pixel with the one-cycle tap read latency
    sync_p0_d = '{vsync: per_frame_vsync, href: per_frame_href, clken: per_frame_clken};
    pix_p0_d  = per_img_y;
    sync_p1_d = sync_p0_q;
    sync_p2_d = sync_p1_q;
    sync_p3_d = sync_p2_q;
    sync_p4_d = sync_p3_q;

    // Stage 1: window shift, position counters, border marking
    win_d       = win_q;
    raw_p1_d    = raw_p1_q;
    border_p1_d = border_p1_q;
    if (vld_p0) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = taps1x;
      win_d[1][2] = taps0x;
      win_d[2][2] = pix_p0_q;
      raw_p1_d    = pix_p0_q;
      border_p1_d = (row_cnt_q < CNT_W'(2)) || (col_cnt_q < CNT_W'(2));
    end

    col_cnt_d = col_cnt_q;
    if (!sync_p0_q.href)                  col_cnt_d = '0;
    else if (vld_p0 && col_cnt_q != '1)   col_cnt_d = col_cnt_q + CNT_W'(1);

    row_cnt_d = row_cnt_q;
    if (vs_rise)                          row_cnt_d = '0;
    else if (href_fall && row_cnt_q != '1) row_cnt_d = row_cnt_q + CNT_W'(1);

    // Stage 2: row sums
    rsum_p2_d   = rsum_p2_q;
    raw_p2_d    = raw_p2_q;
    border_p2_d = border_p2_q;
    if (vld_p1) begin
      for (int r = 0; r < 3; r++)
        rsum_p2_d[r] = ROW_W'(win_q[r][0]) + ROW_W'(win_q[r][1]) + ROW_W'(win_q[r][2]);
      raw_p2_d    = raw_p1_q;
      border_p2_d = border_p1_q;
    end

    // Stage 3: window total
    sum_p3_d    = sum_p3_q;
    raw_p3_d    = raw_p3_q;
    border_p3_d = border_p3_q;
    if (vld_p2) begin
      sum_p3_d    = SUM_W'(rsum_p2_q[0]) + SUM_W'(rsum_p2_q[1]) + SUM_W'(rsum_p2_q[2]);
      raw_p3_d    = raw_p2_q;
      border_p3_d = border_p2_q;
    end

    // Stage 4: border side-band tracks the divider register
    raw_p4_d    = raw_p4_q;
    border_p4_d = border_p4_q;
    if (vld_p3) begin
      raw_p4_d    = raw_p3_q;
      border_p4_d = border_p3_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0_q   <= '0;
      sync_p1_q   <= '0;
      sync_p2_q   <= '0;
      sync_p3_q   <= '0;
      sync_p4_q   <= '0;
      pix_p0_q    <= '0;
      raw_p1_q    <= '0;
      raw_p2_q    <= '0;
      raw_p3_q    <= '0;
      raw_p4_q    <= '0;
      border_p1_q <= 1'b0;
      border_p2_q <= 1'b0;
      border_p3_q <= 1'b0;
      border_p4_q <= 1'b0;
      win_q       <= '0;
      rsum_p2_q   <= '0;
      sum_p3_q    <= '0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
    end else begin
      sync_p0_q   <= sync_p0_d;
      sync_p1_q   <= sync_p1_d;
      sync_p2_q   <= sync_p2_d;
      sync_p3_q   <= sync_p3_d;
      sync_p4_q   <= sync_p4_d;
      pix_p0_q    <= pix_p0_d;
      raw_p1_q    <= raw_p1_d;
      raw_p2_q    <= raw_p2_d;
      raw_p3_q    <= raw_p3_d;
      raw_p4_q    <= raw_p4_d;
      border_p1_q <= border_p1_d;
      border_p2_q <= border_p2_d;
      border_p3_q <= border_p3_d;
      border_p4_q <= border_p4_d;
      win_q       <= win_d;
      rsum_p2_q   <= rsum_p2_d;
      sum_p3_q    <= sum_p3_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

  mean_div9 u_div9 (
    .clock  (clock),
    .rst_n  (rst_n),
    .en     (vld_p3),
    .sum_i  (sum_p3_q),
    .mean_o (mean_p4)
  );

  assign post_frame_vsync = sync_p4_q.vsync;
  assign post_frame_href  = sync_p4_q.href;
  assign post_frame_clken = sync_p4_q.clken;
  assign post_img_y       = border_p4_q ? (BORDER_RAW ? raw_p4_q : '0) : mean_p4;

endmodule

// File: tb/tb_mean3x3_window_core.sv
// Scoreboard bench: two instances (raw and zeroed borders) share one stimulus stream.
module tb_mean3x3_window_core;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       per_frame_vsync = 1'b0, per_frame_href = 1'b0, per_frame_clken = 1'b0;
  logic [7:0] per_img_y = '0, taps0x = '0, taps1x = '0;
  logic       vs_r, hr_r, ce_r, vs_z, hr_z, ce_z;
  logic [7:0] y_r, y_z;

  always #5 clock = ~clock;

  mean3x3_window_core #(.CNT_W(12), .BORDER_RAW(1'b1)) u_raw (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .taps0x(taps0x), .taps1x(taps1x),
    .post_frame_vsync(vs_r), .post_frame_href(hr_r),
    .post_frame_clken(ce_r), .post_img_y(y_r));

  mean3x3_window_core #(.CNT_W(12), .BORDER_RAW(1'b0)) u_zero (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_y(per_img_y),
    .taps0x(taps0x), .taps1x(taps1x),
    .post_frame_vsync(vs_z), .post_frame_href(hr_z),
    .post_frame_clken(ce_z), .post_img_y(y_z));

  typedef struct packed {
    logic [7:0] raw;
    logic [7:0] zero;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] img [0:7][0:9];
  logic [7:0] nt0 = '0, nt1 = '0;
  logic [7:0] last_raw = '0, last_zero = '0;
  logic [4:0] hist;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Input clken delayed by five edges, as the output strobe must be.
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) hist <= '0;
    else        hist <= {hist[3:0], per_frame_clken};
  end

  always @(negedge clock) begin
    if (rst_n) begin
      check_eq("clken_lat_raw", ce_r, hist[4]);
      check_eq("clken_lat_zero", ce_z, hist[4]);
      if (ce_r && hr_r) begin
        check_eq("sb_nonempty", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("pix_raw", y_r, e.raw);
          check_eq("pix_zero", y_z, e.zero);
          last_raw  = e.raw;
          last_zero = e.zero;
        end
      end else begin
        check_eq("hold_raw", y_r, last_raw);
        check_eq("hold_zero", y_z, last_zero);
      end
    end
  end

  function automatic int mean_at(input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'(img[r-2+i][c-2+j]);
    return (s + 4) / 9;
  endfunction

  task automatic drive(input logic vs, input logic hr, input logic ce,
                       input logic [7:0] y, input logic [7:0] t0, input logic [7:0] t1);
    @(posedge clock);
    #1;
    taps0x = nt0;
    taps1x = nt1;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = ce;
    per_img_y       = y;
    nt0 = t0;
    nt1 = t1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  // abort_at < 0 runs the whole frame; otherwise stop mid-line after that many pixels.
  task automatic run_frame(input int w, input int h, input int gap_pct, input int abort_at);
    int npix = 0;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    idle(2);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_t e;
        logic [7:0] t0, t1;
        if (abort_at >= 0 && npix == abort_at) return;
        while (c > 0 && int'($urandom_range(99)) < gap_pct)
          drive(1'b0, 1'b1, 1'b0, 8'hA5, 8'd0, 8'd0);
        t0 = (r >= 1) ? img[r-1][c] : 8'd0;
        t1 = (r >= 2) ? img[r-2][c] : 8'd0;
        if (r < 2 || c < 2) begin
          e.raw  = img[r][c];
          e.zero = 8'd0;
        end else begin
          e.raw  = 8'(mean_at(r, c));
          e.zero = e.raw;
        end
        exp_q.push_back(e);
        drive(1'b0, 1'b1, 1'b1, img[r][c], t0, t1);
        npix++;
      end
      idle(3);
    end
    idle(2);
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        img[r][c] = 8'(v);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++)
        img[r][c] = 8'($urandom_range(255));
  endtask

  initial begin
    fill(0);
    #23;
    check_eq("rst_y_raw", y_r, 0);
    check_eq("rst_clken", ce_r, 0);
    check_eq("rst_href", hr_r, 0);
    check_eq("rst_vsync", vs_r, 0);
    check_eq("rst_y_zero", y_z, 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Uniform frame, gapless.
    fill(100);
    run_frame(8, 6, 0, -1);

    // 1..9 patch, isolated 4 and 5 in a zero background.
    fill(0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        img[2+i][2+j] = 8'(i*3 + j + 1);
    img[2][8] = 8'd4;
    img[6][8] = 8'd5;
    run_frame(10, 8, 0, -1);

    // Saturation with gaps.
    fill(255);
    run_frame(8, 6, 30, -1);

    // Random images with gaps, two frames back to back.
    fill_random();
    run_frame(10, 8, 40, -1);
    fill_random();
    run_frame(10, 8, 25, -1);

    // Reset mid-line, then a fresh frame.
    fill_random();
    run_frame(10, 8, 20, 25);
    @(posedge clock);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_y_raw", y_r, 0);
    check_eq("midrst_clken", ce_r, 0);
    check_eq("midrst_href", hr_r, 0);
    check_eq("midrst_vsync", vs_r, 0);
    check_eq("midrst_y_zero", y_z, 0);
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    exp_q.delete();
    last_raw  = '0;
    last_zero = '0;
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;
    idle(2);
    fill_random();
    run_frame(10, 8, 15, -1);

    idle(12);
    check_eq("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
